// File: rtl/interrupt_request_unit.sv
// Interrupt request unit: edge-latches maskable and NMI requests and hands one at a time to the Controller.
// Optional IRQ_COUNT_EN adds an 8-bit saturating count of maskable acknowledges (IrqCount).
module interrupt_request_unit #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = 2
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NUM_SRC-1:0] IrqIn,
    input  logic [NUM_SRC-1:0] IrqMask,
    input  logic               NmiIn,
    input  logic               IntEnable,
    input  logic               IntAck,
    input  logic               NmiAck,
    input  logic               Eret,
    output logic               INT,
    output logic               NMI,
    output logic [CAUSE_W-1:0] IrqCause,
    output logic               InService,
`ifdef IRQ_COUNT_EN
    output logic [7:0]         IrqCount,
`endif
    output logic [NUM_SRC-1:0] PendingOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NUM_SRC-1:0] irq_in_q, irq_in_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] rise, eligible;
    logic               nmi_in_q, nmi_in_d;
    logic               nmi_pend_q, nmi_pend_d;
    logic               nmi_rise;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [CAUSE_W-1:0] winner;
    logic               ack_take;

    always_comb begin
        rise     = IrqIn & ~irq_in_q;
        nmi_rise = NmiIn & ~nmi_in_q;
        eligible = pending_q & ~IrqMask;
        irq_in_d = IrqIn;
        nmi_in_d = NmiIn;
    end

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CAUSE_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pending_d = pending_q;
        ack_take  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((eligible != '0) && IntEnable && !nmi_pend_q) begin
                    state_d = REQ;
                    cause_d = winner;
                end
            end
            REQ: begin
                if (IntAck) begin
                    state_d            = SERVICE;
                    ack_take           = 1'b1;
                    pending_d[cause_q] = 1'b0;
                end else if (!IntEnable || nmi_pend_q) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (Eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new edge on the acknowledged source re-arms it.
        pending_d = pending_d | rise;
    end

    always_comb begin
        nmi_pend_d = nmi_pend_q;
        if (nmi_rise) nmi_pend_d = 1'b1;
        else if (NmiAck) nmi_pend_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            irq_in_q   <= '0;
            pending_q  <= '0;
            nmi_in_q   <= 1'b0;
            nmi_pend_q <= 1'b0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            irq_in_q   <= irq_in_d;
            pending_q  <= pending_d;
            nmi_in_q   <= nmi_in_d;
            nmi_pend_q <= nmi_pend_d;
            cause_q    <= cause_d;
        end
    end

`ifdef IRQ_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (ack_take && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) count_q <= 8'd0;
        else        count_q <= count_d;
    end

    assign IrqCount = count_q;
`endif

    assign INT        = (state_q == REQ);
    assign InService  = (state_q == SERVICE);
    assign NMI        = nmi_pend_q;
    assign IrqCause   = cause_q;
    assign PendingOut = pending_q;

endmodule

// File: doc/interrupt_request_unit.md
Name: interrupt_request_unit

Overview:
- Interrupt source side of the CPU controller's interrupt interface: detects, latches and prioritises external requests.
- Drives INT/NMI into the multicycle Controller and consumes its acknowledges (intrupt, nmi_intrupt) plus an exception-return strobe.
- Presents a frozen cause index so the handler can identify the serviced source.
- Sits between external peripherals and the Controller; one instance per core.

Parameters:
- NUM_SRC, 4, number of maskable sources (2..16).
- CAUSE_W, 2, width of IrqCause; must equal ceil(log2(NUM_SRC)).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- IrqIn  in  NUM_SRC  level inputs from peripherals, already synchronous to Clk.
- IrqMask  in  NUM_SRC  1 = source masked.
- NmiIn  in  1  non-maskable request input.
- IntEnable  in  1  global maskable-interrupt enable.
- IntAck  in  1  one-cycle ack from Controller (its intrupt output).
- NmiAck  in  1  one-cycle ack from Controller (its nmi_intrupt output).
- Eret  in  1  one-cycle return-from-interrupt strobe.
- INT  out  1  maskable request to Controller.
- NMI  out  1  non-maskable request to Controller.
- IrqCause  out  CAUSE_W  index of requested/in-service source.
- InService  out  1  maskable handler active.
- PendingOut  out  NUM_SRC  raw pending register, for debug/readback.

Behaviour:
- Reset: all outputs 0, Pending = 0, state IDLE, edge registers IrqIn_d and NmiIn_d = 0.
  - An input already high when reset releases counts as a rising edge on the first clock.
- Edge detect: IrqIn_d <= IrqIn each cycle. Rise[i] = IrqIn[i] & ~IrqIn_d[i]. Rise[i] sets Pending[i] on the same edge.
- Masking: masked sources still latch Pending. Masking only blocks selection.
- Selection: Eligible = Pending & ~IrqMask. The winner is the lowest set index (index 0 is highest priority).
- NMI:
  - A rising edge of NmiIn sets NmiPend. NMI = NmiPend, so latency is 1 clock from the sampled edge.
  - NmiAck clears NmiPend. Further NMI edges while NmiPend is set coalesce.
  - If a new edge and NmiAck occur in the same cycle, the set wins.
- Maskable FSM:
  - IDLE: if Eligible != 0 and IntEnable and !NmiPend, go to REQ and latch IrqCause = winner. Otherwise stay.
  - REQ: INT = 1 and IrqCause is frozen.
    - IntAck: go to SERVICE and clear Pending[IrqCause]. If Rise[IrqCause] occurs in the same cycle, the set wins and the bit stays pending.
    - IntEnable drops or NmiPend rises before IntAck: return to IDLE with INT = 0 next cycle; Pending is unchanged.
  - SERVICE: INT = 0, InService = 1, IrqCause held. Eret goes to IDLE, and IrqCause keeps its last value.
- Latency:
  - Maskable: IrqIn high before edge k gives Pending at k, REQ at k+1, INT high after k+1 (2 clocks).
  - Back-to-back: Eret at edge m with another source eligible gives REQ at m+1.
- Ignored strobes: IntAck outside REQ, Eret outside SERVICE, and NmiAck with NmiPend = 0 have no effect.
- NMI during SERVICE: NMI is still asserted. InService is unaffected, so nesting is the Controller's job.
- Reset mid-operation: asynchronous return to the reset values above; any in-flight request is dropped.
- INT, NMI, InService and IrqCause are registered outputs; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro IRQ_COUNT_EN.
- Defined:
  - Adds output IrqCount, 8 bits, counting maskable acknowledges (REQ to SERVICE transitions).
  - Saturates at 255; reset value 0; NMI acks are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with IrqIn=4'b0000, then IrqIn[2] rises, IntEnable=1 -> INT=1 two clocks later with IrqCause=2; IntAck -> next cycle INT=0, InService=1, PendingOut=0; Eret -> InService=0.
- IrqIn[3] and IrqIn[1] rise together with IrqMask=4'b0010 -> IrqCause=3 first. After Ack/Eret with IrqMask=0 -> second REQ with IrqCause=1 on the cycle after Eret.
- Unit in REQ with IrqCause=0, NmiIn rises -> NMI=1 one clock later, INT=0 the following cycle, Pending[0] kept. NmiAck -> NMI=0, then INT=1 with IrqCause=0 again.
- IntEnable=0 while Pending=4'b0100 -> INT stays 0 for 20 cycles. IntEnable=1 -> INT=1 one clock later.
- In SERVICE assert Rst_n=0 mid-cycle -> INT, NMI, InService, IrqCause and PendingOut all 0 immediately. With IrqIn[0] held high through release -> Pending[0]=1 on the first clock.
- With IRQ_COUNT_EN defined, 260 acknowledged interrupts -> IrqCount=255. Spurious IntAck in IDLE -> count unchanged.
